// File: rtl/booth_seq_mult.sv
// Sequential signed radix-2 Booth multiplier: one multiplier bit per clock, start/busy/done handshake.
// Define BOOTH_EARLY_TERM_EN to finish early once the remaining multiplier bits can no longer trigger an add/sub.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = 2 * WIDTH + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic [WIDTH-1:0]     m_reg, m_next;
    logic [WIDTH:0]       h_reg, h_next;
    logic [WIDTH-1:0]     l_reg, l_next;
    logic                 q_reg, q_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;

    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       h_sum;
    logic signed [AW-1:0] acc_step;
    logic signed [AW-1:0] acc_shift;
    logic signed [AW-1:0] acc_new;
    logic [CW-1:0]        cnt_new;
    logic                 accept;
    logic                 last;

    assign m_ext  = {m_reg[WIDTH-1], m_reg};
    assign accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    always_comb begin
        case ({l_reg[0], q_reg})
            2'b01:   h_sum = h_reg + m_ext;
            2'b10:   h_sum = h_reg - m_ext;
            default: h_sum = h_reg;
        endcase
    end

    assign acc_step  = {h_sum, l_reg, q_reg};
    assign acc_shift = acc_step >>> 1;

`ifdef BOOTH_EARLY_TERM_EN
    // Early exit when {L[cnt-1:0], q} is uniform: every remaining Booth pair is 00 or 11.
    logic [WIDTH-1:0]     bit_diff;
    logic                 early;
    logic signed [AW-1:0] acc_cur;
    logic signed [AW-1:0] acc_early;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
        assign bit_diff[gi] = (CW'(gi) < cnt_reg) && (l_reg[gi] != q_reg);
    end

    assign early     = ~|bit_diff;
    assign acc_cur   = {h_reg, l_reg, q_reg};
    assign acc_early = acc_cur >>> cnt_reg;
    assign acc_new   = early ? acc_early : acc_shift;
    assign cnt_new   = early ? '0 : CW'(cnt_reg - 1'b1);
`else
    assign acc_new   = acc_shift;
    assign cnt_new   = CW'(cnt_reg - 1'b1);
`endif

    assign last = (cnt_new == '0);

    always_comb begin
        state_next   = state_reg;
        m_next       = m_reg;
        h_next       = h_reg;
        l_next       = l_reg;
        q_next       = q_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        case (state_reg)
            ST_IDLE: state_next = ST_IDLE;
            ST_RUN: begin
                h_next   = acc_new[AW-1:WIDTH+1];
                l_next   = acc_new[WIDTH:1];
                q_next   = acc_new[0];
                cnt_next = cnt_new;
                if (last) begin
                    state_next   = ST_DONE;
                    product_next = acc_new[2*WIDTH:1];
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        if (accept) begin
            state_next = ST_RUN;
            m_next     = a;
            h_next     = '0;
            l_next     = b;
            q_next     = 1'b0;
            cnt_next   = CW'(WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            m_reg       <= '0;
            h_reg       <= '0;
            l_reg       <= '0;
            q_reg       <= 1'b0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            m_reg       <= m_next;
            h_reg       <= h_next;
            l_reg       <= l_next;
            q_reg       <= q_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    assign busy    = (state_reg == ST_RUN);
    assign done    = (state_reg == ST_DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: WIDTH=8 and WIDTH=4 instances against a plain-arithmetic model.
// Latency expectations follow BOOTH_EARLY_TERM_EN when the bench is built with it.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  prod4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    booth_seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Number of RUN cycles from the operand b alone: early exit at the first cycle j
    // whose remaining bits b[w-1:j] all equal the shifted-in bit b[j-1] (0 for j=0).
    function automatic int exp_runs(input logic [31:0] b, input int w);
`ifdef BOOTH_EARLY_TERM_EN
        for (int j = 0; j < w; j++) begin
            logic q;
            bit   same;
            q    = (j == 0) ? 1'b0 : b[j-1];
            same = 1'b1;
            for (int k = j; k < w; k++)
                if (b[k] != q) same = 1'b0;
            if (same) return j + 1;
        end
`endif
        return w;
    endfunction

    // One WIDTH=8 operation; optionally wiggles start/a/b while busy.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit toggle);
        int          runs;
        int          guard;
        logic [15:0] exp_p;
        exp_p  = 16'(int'($signed(a)) * int'($signed(b)));
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        runs   = 0;
        guard  = 0;
        while (busy8 && guard < 40) begin
            check("busy_done_overlap", {63'b0, done8}, 64'd0);
            runs++;
            if (toggle) begin
                start8 = runs[0];
                a8     = 8'($urandom);
                b8     = 8'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        start8 = 1'b0;
        check("run_cycles", 64'(runs), 64'(exp_runs(32'(b), 8)));
        check("done_after_run", {63'b0, done8}, 64'd1);
        check("product", 64'(prod8), 64'(exp_p));
        $display("op8 a=%0d b=%0d product=%0d runs=%0d", $signed(a), $signed(b), $signed(prod8), runs);
        @(posedge clk); #1;
        check("done_single", {63'b0, done8}, 64'd0);
        check("idle_after_done", {63'b0, busy8}, 64'd0);
        check("product_held", 64'(prod8), 64'(exp_p));
    endtask

    initial begin
        int          cycles;
        logic [3:0]  ai, bi;
        logic [7:0]  exp4;

        tbl[0] = '{8'd3,    8'd5,    16'h000F};
        tbl[1] = '{8'h80,   8'h80,   16'h4000};
        tbl[2] = '{8'h80,   8'h7F,   16'hC080};
        tbl[3] = '{8'd0,    8'hB3,   16'h0000};
        tbl[4] = '{8'hFF,   8'hFF,   16'h0001};
        tbl[5] = '{8'h7F,   8'h7F,   16'h3F01};
        tbl[6] = '{8'd1,    8'hFF,   16'hFFFF};
        tbl[7] = '{8'd9,    8'd1,    16'h0009};
        tbl[8] = '{8'h25,   8'd0,    16'h0000};
        tbl[9] = '{8'hF6,   8'h55,   16'hFCAE};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy8", {63'b0, busy8}, 64'd0);
        check("reset_done8", {63'b0, done8}, 64'd0);
        check("reset_prod8", 64'(prod8), 64'd0);
        check("reset_prod4", 64'(prod4), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run8(tbl[i].a, tbl[i].b, 1'b0);
            check("table_product", 64'(prod8), 64'(tbl[i].p));
        end

        // start and operands wiggled during RUN must be ignored
        run8(8'h9C, 8'd57, 1'b1);

        // Random operations against plain signed multiplication
        for (int i = 0; i < 40; i++)
            run8(8'($urandom), 8'($urandom), 1'b0);

        // Asynchronous reset in the fourth RUN cycle
        a8 = 8'd77; b8 = 8'h55; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("busy_before_abort", {63'b0, busy8}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy8}, 64'd0);
        check("abort_done", {63'b0, done8}, 64'd0);
        check("abort_product", 64'(prod8), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        $display("op8 reset applied mid-run");
        run8(8'hE7, 8'd100, 1'b0);

        // WIDTH=4: all 256 pairs back-to-back with start held high
        a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ai     = 4'(i >> 4);
            bi     = 4'(i);
            exp4   = 8'(int'($signed(ai)) * int'($signed(bi)));
            cycles = 0;
            do begin
                @(posedge clk); #1;
                cycles++;
            end while (!done4 && cycles < 20);
            check("b2b_spacing", 64'(cycles), 64'(exp_runs(32'(bi), 4) + 1));
            check("b2b_product", 64'(prod4), 64'(exp4));
            $display("op4 a=%0d b=%0d product=%0d cycles=%0d", $signed(ai), $signed(bi), $signed(prod4), cycles);
            if (i < 255) begin
                a4 = 4'((i + 1) >> 4);
                b4 = 4'(i + 1);
            end else begin
                start4 = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("b2b_final_idle", {62'b0, busy4, done4}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
